// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer slice (package fetch_pkg).

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    FAULT
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES     = 4;
  localparam logic [31:0] PC_STEP         = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM, decode handshake and redirect signals of the fetch sequencer.

interface fetch_sequencer_if;
  logic        run;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        instr_fault;

  modport master (
    input  run, mem_rdata, instr_ready, redirect_valid, redirect_pc,
    output mem_addr, instr, instr_pc, instr_valid, busy, instr_fault
  );

  modport slave (
    output run, mem_rdata, instr_ready, redirect_valid, redirect_pc,
    input  mem_addr, instr, instr_pc, instr_valid, busy, instr_fault
  );
endinterface

// File: rtl/fetch_sequencer_assembler.sv
// instr_byte_assembler: 4-byte big-endian shift register with byte counter and done pulse.

module instr_byte_assembler
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        done
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
    end else if (shift_en) begin
      word_q <= {word_q[23:0], byte_in};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word     = word_q;
  assign byte_cnt = cnt_q;
  assign done     = shift_en && !clear && (cnt_q == 2'(INSTR_BYTES - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, assembles 32-bit instructions from a byte ROM, handshakes to decode.
// Optional ROM bound check enabled by defining FETCH_BOUND_CHECK_EN.

module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end
  if (MEM_BYTES < INSTR_BYTES) begin : g_bad_mem_bytes
    $error("MEM_BYTES must hold at least one instruction");
  end

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic         shift_en, asm_clear, asm_done;
  logic [31:0]  asm_word;
  logic [1:0]   byte_cnt;
  logic         handshake;

  instr_byte_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (asm_clear),
    .shift_en (shift_en),
    .byte_in  (bus.mem_rdata),
    .word     (asm_word),
    .byte_cnt (byte_cnt),
    .done     (asm_done)
  );

  assign handshake = valid_q && bus.instr_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    shift_en   = 1'b0;
    asm_clear  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.run) state_d = FETCH;
      end
      FETCH: begin
        shift_en = 1'b1;
        if (asm_done) begin
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          valid_d = 1'b0;
          pc_d    = pc_q + PC_STEP;
          state_d = bus.run ? FETCH : IDLE;
        end
      end
`ifdef FETCH_BOUND_CHECK_EN
      FAULT: begin
        valid_d = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything, including a same-cycle HOLD handshake.
    if (bus.redirect_valid) begin
      pc_d      = align_pc(bus.redirect_pc);
      asm_clear = 1'b1;
      shift_en  = 1'b0;
      valid_d   = 1'b0;
      state_d   = bus.run ? FETCH : IDLE;
    end

`ifdef FETCH_BOUND_CHECK_EN
    // Every (re)entry into FETCH is checked against the PC it will read from.
    if ((state_d == FETCH) && ((state_q != FETCH) || bus.redirect_valid) &&
        (pc_d > 32'(MEM_BYTES - INSTR_BYTES)))
      state_d = FAULT;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.mem_addr    = pc_q + 32'(byte_cnt);
  assign bus.instr       = asm_word;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.busy        = (state_q != IDLE);
`ifdef FETCH_BOUND_CHECK_EN
  assign bus.instr_fault = (state_q == FAULT);
`else
  assign bus.instr_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; ROM byte i holds i, except bytes 0..7.

module tb_fetch_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   xfer_cnt = 0;
  logic [7:0] rom [0:255];

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (256)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.mem_rdata = rom[bus.mem_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.instr_valid && bus.instr_ready) xfer_cnt <= xfer_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.run = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    cyc(2);
    n_cmp++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want %h", bus.mem_addr, 32'h0); end
    n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want %h", bus.instr, 32'h0); end
    n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_instr_pc: got %h want %h", bus.instr_pc, 32'h0); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.instr_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", bus.instr_fault); end
    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic_fetch();
    do_reset();
    bus.run = 1'b1;
    bus.instr_ready = 1'b1;
    cyc(1);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.mem_addr !== 32'(i)) begin n_err++; $display("FAIL basic_mem_addr[%0d]: got %h want %h", i, bus.mem_addr, 32'(i)); end
      n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, bus.instr_valid); end
      cyc(1);
    end
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid0: got %b want 1", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h0123_4567) begin n_err++; $display("FAIL basic_instr0: got %h want %h", bus.instr, 32'h0123_4567); end
    n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL basic_pc0: got %h want %h", bus.instr_pc, 32'h0); end
    cyc(4);
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL basic_gap_valid: got %b want 0", bus.instr_valid); end
    cyc(1);
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid1: got %b want 1", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h89AB_CDEF) begin n_err++; $display("FAIL basic_instr1: got %h want %h", bus.instr, 32'h89AB_CDEF); end
    n_cmp++; if (bus.instr_pc !== 32'h4) begin n_err++; $display("FAIL basic_pc1: got %h want %h", bus.instr_pc, 32'h4); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.instr_valid); end
      n_cmp++; if (bus.instr !== 32'h89AB_CDEF) begin n_err++; $display("FAIL stall_instr[%0d]: got %h want %h", i, bus.instr, 32'h89AB_CDEF); end
      n_cmp++; if (bus.instr_pc !== 32'h4) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want %h", i, bus.instr_pc, 32'h4); end
      n_cmp++; if (bus.mem_addr !== 32'h4) begin n_err++; $display("FAIL stall_mem_addr[%0d]: got %h want %h", i, bus.mem_addr, 32'h4); end
    end
    bus.instr_ready = 1'b1;
    cyc(1);
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_release_valid: got %b want 0", bus.instr_valid); end
    n_cmp++; if (bus.mem_addr !== 32'h8) begin n_err++; $display("FAIL stall_release_addr: got %h want %h", bus.mem_addr, 32'h8); end
    cyc(4);
    n_cmp++; if (bus.instr !== 32'h0809_0A0B) begin n_err++; $display("FAIL stall_next_instr: got %h want %h", bus.instr, 32'h0809_0A0B); end
    n_cmp++; if (bus.instr_pc !== 32'h8) begin n_err++; $display("FAIL stall_next_pc: got %h want %h", bus.instr_pc, 32'h8); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_redirect_partial();
    do_reset();
    bus.run = 1'b1;
    bus.instr_ready = 1'b1;
    cyc(3);
    n_cmp++; if (bus.mem_addr !== 32'h2) begin n_err++; $display("FAIL redir_pre_addr: got %h want %h", bus.mem_addr, 32'h2); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0013;
    cyc(1);
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b want 0", bus.instr_valid); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.mem_addr !== 32'h10 + 32'(i)) begin n_err++; $display("FAIL redir_addr[%0d]: got %h want %h", i, bus.mem_addr, 32'h10 + 32'(i)); end
      cyc(1);
    end
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL redir_done_valid: got %b want 1", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h1011_1213) begin n_err++; $display("FAIL redir_instr: got %h want %h", bus.instr, 32'h1011_1213); end
    n_cmp++; if (bus.instr_pc !== 32'h10) begin n_err++; $display("FAIL redir_pc: got %h want %h", bus.instr_pc, 32'h10); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_redirect_handshake();
    int x0;
    do_reset();
    bus.run = 1'b1;
    cyc(5);
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL rhs_valid: got %b want 1", bus.instr_valid); end
    x0 = xfer_cnt;
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    cyc(1);
    bus.redirect_valid = 1'b0;
    bus.instr_ready = 1'b0;
    n_cmp++; if (xfer_cnt - x0 !== 1) begin n_err++; $display("FAIL rhs_xfer: got %0d want 1", xfer_cnt - x0); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rhs_valid_drop: got %b want 0", bus.instr_valid); end
    n_cmp++; if (bus.mem_addr !== 32'h40) begin n_err++; $display("FAIL rhs_addr: got %h want %h", bus.mem_addr, 32'h40); end
    cyc(4);
    n_cmp++; if (bus.instr_pc !== 32'h40) begin n_err++; $display("FAIL rhs_pc: got %h want %h", bus.instr_pc, 32'h40); end
    n_cmp++; if (bus.instr !== 32'h4041_4243) begin n_err++; $display("FAIL rhs_instr: got %h want %h", bus.instr, 32'h4041_4243); end
    cyc(2);
    n_cmp++; if (xfer_cnt - x0 !== 1) begin n_err++; $display("FAIL rhs_xfer_once: got %0d want 1", xfer_cnt - x0); end
  endtask

  task automatic test_run_drop();
    do_reset();
    bus.run = 1'b1;
    cyc(2);
    bus.run = 1'b0;
    cyc(3);
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL rundrop_valid: got %b want 1", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h0123_4567) begin n_err++; $display("FAIL rundrop_instr: got %h want %h", bus.instr, 32'h0123_4567); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rundrop_busy_hold: got %b want 1", bus.busy); end
    bus.instr_ready = 1'b1;
    cyc(1);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rundrop_idle: got %b want 0", bus.busy); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rundrop_valid_drop: got %b want 0", bus.instr_valid); end
    cyc(3);
    n_cmp++; if (bus.mem_addr !== 32'h4) begin n_err++; $display("FAIL rundrop_addr: got %h want %h", bus.mem_addr, 32'h4); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rundrop_stay_idle: got %b want 0", bus.busy); end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    bus.run = 1'b1;
    bus.instr_ready = 1'b1;
    cyc(8);
    n_cmp++; if (bus.mem_addr !== 32'h6) begin n_err++; $display("FAIL midrst_pre_addr: got %h want %h", bus.mem_addr, 32'h6); end
    n_cmp++; if (bus.instr !== 32'h4567_89AB) begin n_err++; $display("FAIL midrst_pre_instr: got %h want %h", bus.instr, 32'h4567_89AB); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL midrst_addr: got %h want %h", bus.mem_addr, 32'h0); end
    n_cmp++; if (bus.instr !== 32'h0) begin n_err++; $display("FAIL midrst_instr: got %h want %h", bus.instr, 32'h0); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", bus.instr_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  task automatic test_redirect_idle();
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0023;
    cyc(1);
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.mem_addr !== 32'h20) begin n_err++; $display("FAIL ridle_addr: got %h want %h", bus.mem_addr, 32'h20); end
    cyc(2);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ridle_busy: got %b want 0", bus.busy); end
    bus.run = 1'b1;
    cyc(5);
    n_cmp++; if (bus.instr !== 32'h2021_2223) begin n_err++; $display("FAIL ridle_instr: got %h want %h", bus.instr, 32'h2021_2223); end
    n_cmp++; if (bus.instr_pc !== 32'h20) begin n_err++; $display("FAIL ridle_pc: got %h want %h", bus.instr_pc, 32'h20); end
  endtask

  task automatic test_bound();
    do_reset();
    bus.run = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_00FE;
    cyc(1);
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.mem_addr !== 32'hFC) begin n_err++; $display("FAIL bound_align: got %h want %h", bus.mem_addr, 32'hFC); end
    cyc(4);
    n_cmp++; if (bus.instr !== 32'hFCFD_FEFF) begin n_err++; $display("FAIL bound_last_instr: got %h want %h", bus.instr, 32'hFCFD_FEFF); end
    n_cmp++; if (bus.instr_pc !== 32'hFC) begin n_err++; $display("FAIL bound_last_pc: got %h want %h", bus.instr_pc, 32'hFC); end
    n_cmp++; if (bus.instr_fault !== 1'b0) begin n_err++; $display("FAIL bound_last_fault: got %b want 0", bus.instr_fault); end
    bus.instr_ready = 1'b1;
    cyc(1);
    bus.instr_ready = 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
    n_cmp++; if (bus.instr_fault !== 1'b1) begin n_err++; $display("FAIL bound_fault: got %b want 1", bus.instr_fault); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL bound_busy: got %b want 1", bus.busy); end
    cyc(2);
    n_cmp++; if (bus.instr_fault !== 1'b1) begin n_err++; $display("FAIL bound_fault_sticky: got %b want 1", bus.instr_fault); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL bound_valid: got %b want 0", bus.instr_valid); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    cyc(1);
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.instr_fault !== 1'b0) begin n_err++; $display("FAIL bound_clear: got %b want 0", bus.instr_fault); end
    cyc(4);
    n_cmp++; if (bus.instr !== 32'h0123_4567) begin n_err++; $display("FAIL bound_resume_instr: got %h want %h", bus.instr, 32'h0123_4567); end
    n_cmp++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL bound_resume_pc: got %h want %h", bus.instr_pc, 32'h0); end
`else
    n_cmp++; if (bus.instr_fault !== 1'b0) begin n_err++; $display("FAIL bound_nofault: got %b want 0", bus.instr_fault); end
    n_cmp++; if (bus.mem_addr !== 32'h100) begin n_err++; $display("FAIL bound_pass_addr: got %h want %h", bus.mem_addr, 32'h100); end
    cyc(4);
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL bound_pass_valid: got %b want 1", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h0123_4567) begin n_err++; $display("FAIL bound_pass_instr: got %h want %h", bus.instr, 32'h0123_4567); end
    n_cmp++; if (bus.instr_pc !== 32'h100) begin n_err++; $display("FAIL bound_pass_pc: got %h want %h", bus.instr_pc, 32'h100); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    rom[0] = 8'h01; rom[1] = 8'h23; rom[2] = 8'h45; rom[3] = 8'h67;
    rom[4] = 8'h89; rom[5] = 8'hAB; rom[6] = 8'hCD; rom[7] = 8'hEF;

    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_redirect_partial();
    test_redirect_handshake();
    test_run_drop();
    test_reset_midfetch();
    test_redirect_idle();
    test_bound();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
